itch_msg_parser: RTL
====================

# itch_msg_parser

Multi-type NASDAQ ITCH 5.0 order-message parser. It sits between the beat-aligned feed deframer and the order book. It accepts a message as a stream of BEAT_BYTES-wide beats and decodes Add (A), Add-MPID (F), Execute (E), Cancel (X), Delete (D) and Replace (U) into one normalised order event per message. It adds input/output valid-ready flow control, length checking and skipping of unsupported messages.

## Interface
Parameters:
- BEAT_BYTES, 4, bytes per input beat; legal range 1..8.
- ID_WIDTH, 64, width of order_id_out and new_order_id_out.
- PRICE_WIDTH, 32, width of price_out.
- QUANT_WIDTH, 32, width of quantity_out.
- STOCK_WIDTH, 16, width of stock_symbol_out (stock locate).

Ports:
- clk_in  in  1  clock; one clock domain.
- reset_n_in  in  1  reset, asynchronous, active-low.
- data_in  in  BEAT_BYTES*8  beat payload; lane 0 (data_in[7:0]) is the earliest byte.
- valid_in  in  1  beat present.
- sop_in  in  1  beat is the first of a message; lane 0 holds the type byte.
- ready_out  out  1  beat accepted when valid_in && ready_out.
- out_valid  out  1  decoded event held on the outputs.
- out_ready_in  in  1  downstream accepts the event.
- operation_out  out  3  1=add, 2=execute, 3=cancel, 4=delete, 5=replace; 0 when idle.
- stock_symbol_out  out  STOCK_WIDTH  stock locate, bytes 1-2.
- order_id_out  out  ID_WIDTH  order reference, bytes 11-18.
- new_order_id_out  out  ID_WIDTH  U only: bytes 19-26; 0 for all other types.
- order_type_out  out  1  A/F only: 1 if byte 19 == 0x53 ('S'), otherwise 0.
- quantity_out  out  QUANT_WIDTH  shares field:
  - A/F: bytes 20-23
  - E/X: bytes 19-22
  - U: bytes 27-30
  - D: 0
- price_out  out  PRICE_WIDTH  price field: A/F bytes 32-35; U bytes 31-34; otherwise 0.
- err_out  out  1  one-cycle pulse on a protocol error.

## Operation
- Field assembly:
  - All multi-byte fields are big-endian; the lowest byte index is the MSB.
  - A field wider than its port keeps its low bits; a narrower field is zero-extended.
- Message lengths in bytes, including the type byte: A 36, F 40, E 31, X 23, D 19, U 35.
  - A message occupies ceil(len/BEAT_BYTES) beats.
  - Lanes past len in the last beat are ignored.
- Storage: a 40-byte capture buffer and a 6-bit byte counter, advanced by BEAT_BYTES per accepted beat.
- State machine:
  - IDLE
    - Accepted beat with sop_in and a supported type → COLLECT, or straight to HOLD if len ≤ BEAT_BYTES.
    - sop_in with an unsupported type → SKIP.
    - Beat without sop_in → dropped, err_out pulses.
  - COLLECT
    - Captures beats.
    - When the counter reaches len → outputs are loaded and the FSM moves to HOLD.
    - Accepted sop_in beat before len is reached → truncation: err_out pulses, partial data is discarded, and the beat starts a new message (decoded as in IDLE).
  - SKIP
    - Discards beats until the next sop_in beat, which is handled as in IDLE.
    - No error is flagged.
  - HOLD
    - out_valid=1; outputs are stable until out_valid && out_ready_in.
    - On acceptance → IDLE, or straight on to the next message if a beat is accepted in the same cycle.
- ready_out = (state != HOLD) || out_ready_in. This gives a single output slot with zero-bubble back-to-back operation.
- Reset (asynchronous, any state, including mid-message):
  - state IDLE, counter 0.
  - All outputs 0, except ready_out=1 (combinational, from IDLE).
  - Partial message discarded.

## Timing
- Latency: out_valid rises on the clock edge that accepts the final beat, i.e. it is visible the cycle after that beat.
- Throughput: one beat per cycle sustained while out_ready_in=1. Minimum spacing is one message per ceil(len/BEAT_BYTES) cycles.
- err_out is high for exactly the cycle following the offending beat.
- Outputs do not change while out_valid && !out_ready_in.

## Structure
- itch_pkg, shared with the rest of the decoder:
  - type-byte constants
  - per-type length constants
  - field byte offsets
  - operation_t enum
  - state_t enum
- One sub-module, itch_field_extract: purely combinational. It takes buffer + type and returns normalised fields, so it can be reused by the book-side replay checker.

## Test plan
- BEAT_BYTES=4, A message (9 beats): ref 0x0000_0000_0000_1234, side 'S', shares 100, locate 7, price 0x0001_86A0, out_ready_in=1. Expected: out_valid the cycle after beat 9, with operation 1, order_id 0x1234, order_type 1, quantity 100, stock 7, price 100000.
- D message (5 beats), immediately followed by X message (6 beats), no idle cycle. Expected: two events, operation 4 then 3, the X event with quantity set; ready_out never drops.
- U message with out_ready_in held 0 for 5 cycles. Expected: outputs are held, ready_out=0, the next sop beat stalls; the event is released on the first out_ready_in=1 cycle, with new_order_id and price from bytes 19-26 and 31-34.
- A message truncated by sop_in at beat 6 (E message). Expected: err_out pulses once, no A event, E event decodes correctly.
- Unsupported type 'S' (12 bytes, 3 beats), then F message. Expected: no event and no err_out for 'S'; F decodes with operation 1.
- reset_n_in asserted at beat 4 of an A message. Expected: all outputs 0 at once; the next clean A message decodes normally.

Source files
------------

// File: rtl/itch_pkg.sv
// Shared ITCH 5.0 decoder definitions: type bytes, message lengths, field
// offsets and the enums used by the order-message parser.
package itch_pkg;

  localparam int BUF_BYTES = 40;

  localparam logic [7:0] TYPE_ADD      = 8'h41;
  localparam logic [7:0] TYPE_ADD_MPID = 8'h46;
  localparam logic [7:0] TYPE_EXECUTE  = 8'h45;
  localparam logic [7:0] TYPE_CANCEL   = 8'h58;
  localparam logic [7:0] TYPE_DELETE   = 8'h44;
  localparam logic [7:0] TYPE_REPLACE  = 8'h55;
  localparam logic [7:0] SIDE_SELL     = 8'h53;

  localparam logic [5:0] LEN_ADD      = 6'd36;
  localparam logic [5:0] LEN_ADD_MPID = 6'd40;
  localparam logic [5:0] LEN_EXECUTE  = 6'd31;
  localparam logic [5:0] LEN_CANCEL   = 6'd23;
  localparam logic [5:0] LEN_DELETE   = 6'd19;
  localparam logic [5:0] LEN_REPLACE  = 6'd35;

  localparam int OFF_LOCATE      = 1;
  localparam int OFF_ORDER_REF   = 11;
  localparam int OFF_SIDE        = 19;
  localparam int OFF_ADD_SHARES  = 20;
  localparam int OFF_ADD_PRICE   = 32;
  localparam int OFF_EXEC_SHARES = 19;
  localparam int OFF_NEW_REF     = 19;
  localparam int OFF_REPL_SHARES = 27;
  localparam int OFF_REPL_PRICE  = 31;

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_ADD     = 3'd1,
    OP_EXECUTE = 3'd2,
    OP_CANCEL  = 3'd3,
    OP_DELETE  = 3'd4,
    OP_REPLACE = 3'd5
  } operation_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    SKIP,
    HOLD
  } state_t;

  // A length of zero marks a type the parser does not decode.
  function automatic logic [5:0] msg_len(input logic [7:0] msg_type);
    case (msg_type)
      TYPE_ADD:      msg_len = LEN_ADD;
      TYPE_ADD_MPID: msg_len = LEN_ADD_MPID;
      TYPE_EXECUTE:  msg_len = LEN_EXECUTE;
      TYPE_CANCEL:   msg_len = LEN_CANCEL;
      TYPE_DELETE:   msg_len = LEN_DELETE;
      TYPE_REPLACE:  msg_len = LEN_REPLACE;
      default:       msg_len = 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/itch_field_extract.sv
// Combinational field decoder: turns a captured message buffer and its type
// byte into one normalised order event.
module itch_field_extract
  import itch_pkg::*;
#(
  parameter int ID_WIDTH    = 64,
  parameter int PRICE_WIDTH = 32,
  parameter int QUANT_WIDTH = 32,
  parameter int STOCK_WIDTH = 16
) (
  input  logic [BUF_BYTES-1:0][7:0] msg_buf,
  input  logic [7:0]                msg_type,
  output operation_t                operation,
  output logic [STOCK_WIDTH-1:0]    stock_symbol,
  output logic [ID_WIDTH-1:0]       order_id,
  output logic [ID_WIDTH-1:0]       new_order_id,
  output logic                      order_type,
  output logic [QUANT_WIDTH-1:0]    quantity,
  output logic [PRICE_WIDTH-1:0]    price
);

  // Big-endian gather: the lowest byte index lands in the most significant byte.
  function automatic logic [63:0] be_field(input logic [BUF_BYTES-1:0][7:0] b,
                                           input int off, input int nbytes);
    logic [63:0] v;
    logic [5:0]  idx;
    v = '0;
    for (int i = 0; i < nbytes; i++) begin
      idx = 6'(off + i);
      v   = {v[55:0], b[idx]};
    end
    return v;
  endfunction

  always_comb begin
    operation    = OP_NONE;
    stock_symbol = '0;
    order_id     = '0;
    new_order_id = '0;
    order_type   = 1'b0;
    quantity     = '0;
    price        = '0;
    case (msg_type)
      TYPE_ADD, TYPE_ADD_MPID: begin
        operation  = OP_ADD;
        order_type = (msg_buf[OFF_SIDE] == SIDE_SELL);
        quantity   = QUANT_WIDTH'(be_field(msg_buf, OFF_ADD_SHARES, 4));
        price      = PRICE_WIDTH'(be_field(msg_buf, OFF_ADD_PRICE, 4));
      end
      TYPE_EXECUTE: begin
        operation = OP_EXECUTE;
        quantity  = QUANT_WIDTH'(be_field(msg_buf, OFF_EXEC_SHARES, 4));
      end
      TYPE_CANCEL: begin
        operation = OP_CANCEL;
        quantity  = QUANT_WIDTH'(be_field(msg_buf, OFF_EXEC_SHARES, 4));
      end
      TYPE_DELETE: begin
        operation = OP_DELETE;
      end
      TYPE_REPLACE: begin
        operation    = OP_REPLACE;
        new_order_id = ID_WIDTH'(be_field(msg_buf, OFF_NEW_REF, 8));
        quantity     = QUANT_WIDTH'(be_field(msg_buf, OFF_REPL_SHARES, 4));
        price        = PRICE_WIDTH'(be_field(msg_buf, OFF_REPL_PRICE, 4));
      end
      default: ;
    endcase
    if (operation != OP_NONE) begin
      stock_symbol = STOCK_WIDTH'(be_field(msg_buf, OFF_LOCATE, 2));
      order_id     = ID_WIDTH'(be_field(msg_buf, OFF_ORDER_REF, 8));
    end
  end

endmodule

// File: rtl/itch_msg_parser.sv
// ITCH 5.0 order-message parser: collects beats into a capture buffer and
// presents one decoded event per supported message through a single slot.
module itch_msg_parser
  import itch_pkg::*;
#(
  parameter int BEAT_BYTES  = 4,
  parameter int ID_WIDTH    = 64,
  parameter int PRICE_WIDTH = 32,
  parameter int QUANT_WIDTH = 32,
  parameter int STOCK_WIDTH = 16
) (
  input  logic                    clk_in,
  input  logic                    reset_n_in,
  input  logic [BEAT_BYTES*8-1:0] data_in,
  input  logic                    valid_in,
  input  logic                    sop_in,
  output logic                    ready_out,
  output logic                    out_valid,
  input  logic                    out_ready_in,
  output logic [2:0]              operation_out,
  output logic [STOCK_WIDTH-1:0]  stock_symbol_out,
  output logic [ID_WIDTH-1:0]     order_id_out,
  output logic [ID_WIDTH-1:0]     new_order_id_out,
  output logic                    order_type_out,
  output logic [QUANT_WIDTH-1:0]  quantity_out,
  output logic [PRICE_WIDTH-1:0]  price_out,
  output logic                    err_out
);

  state_t                   state_q, state_d;
  logic [5:0]               cnt_q, cnt_d;
  logic [BUF_BYTES-1:0][7:0] buf_q, buf_next;
  logic                     accept, wr_en, load, clear, err_d, beat_done;
  logic [5:0]               base, beat_len;
  logic [6:0]               beat_end;

  operation_t               ext_op;
  logic [STOCK_WIDTH-1:0]   ext_stock;
  logic [ID_WIDTH-1:0]      ext_id, ext_new_id;
  logic                     ext_side;
  logic [QUANT_WIDTH-1:0]   ext_qty;
  logic [PRICE_WIDTH-1:0]   ext_price;

  assign ready_out = (state_q != HOLD) || out_ready_in;
  assign out_valid = (state_q == HOLD);
  assign accept    = valid_in && ready_out;
  assign base      = sop_in ? 6'd0 : cnt_q;
  assign beat_end  = {1'b0, base} + 7'(BEAT_BYTES);
  assign beat_len  = sop_in ? msg_len(data_in[7:0]) : msg_len(buf_q[0]);
  assign beat_done = (beat_len != 6'd0) && (beat_end >= {1'b0, beat_len});

  // The decoder looks at the buffer including the current beat, so the event
  // can be registered on the same edge that accepts the final beat.
  always_comb begin
    buf_next = buf_q;
    for (int j = 0; j < BEAT_BYTES; j++) begin
      if (({1'b0, base} + 7'(j)) < 7'(BUF_BYTES))
        buf_next[base + 6'(j)] = data_in[j*8 +: 8];
    end
  end

  itch_field_extract #(
    .ID_WIDTH    (ID_WIDTH),
    .PRICE_WIDTH (PRICE_WIDTH),
    .QUANT_WIDTH (QUANT_WIDTH),
    .STOCK_WIDTH (STOCK_WIDTH)
  ) u_extract (
    .msg_buf      (buf_next),
    .msg_type     (buf_next[0]),
    .operation    (ext_op),
    .stock_symbol (ext_stock),
    .order_id     (ext_id),
    .new_order_id (ext_new_id),
    .order_type   (ext_side),
    .quantity     (ext_qty),
    .price        (ext_price)
  );

  // A sop beat always starts a fresh message; arriving mid-collection it
  // also flags the truncated message it replaces.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    load    = 1'b0;
    clear   = (state_q == HOLD) && out_ready_in;
    if (clear) state_d = IDLE;
    if (accept) begin
      if (sop_in) begin
        wr_en = 1'b1;
        err_d = (state_q == COLLECT);
        if (beat_len == 6'd0) begin
          state_d = SKIP;
          cnt_d   = '0;
        end else if (beat_done) begin
          state_d = HOLD;
          load    = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = COLLECT;
          cnt_d   = beat_end[5:0];
        end
      end else begin
        case (state_q)
          COLLECT: begin
            wr_en = 1'b1;
            if (beat_done) begin
              state_d = HOLD;
              load    = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = beat_end[5:0];
            end
          end
          SKIP:    state_d = SKIP;
          default: err_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      err_out <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_out <= err_d;
      if (wr_en) buf_q <= buf_next;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      operation_out    <= '0;
      stock_symbol_out <= '0;
      order_id_out     <= '0;
      new_order_id_out <= '0;
      order_type_out   <= 1'b0;
      quantity_out     <= '0;
      price_out        <= '0;
    end else if (load) begin
      operation_out    <= ext_op;
      stock_symbol_out <= ext_stock;
      order_id_out     <= ext_id;
      new_order_id_out <= ext_new_id;
      order_type_out   <= ext_side;
      quantity_out     <= ext_qty;
      price_out        <= ext_price;
    end else if (clear) begin
      operation_out    <= '0;
      stock_symbol_out <= '0;
      order_id_out     <= '0;
      new_order_id_out <= '0;
      order_type_out   <= 1'b0;
      quantity_out     <= '0;
      price_out        <= '0;
    end
  end

endmodule
